local_ingress_buffer: RTL and testbench

LOCAL_INGRESS_BUFFER -- requirements
Module: local_ingress_buffer

---
 rtl/local_ingress_buffer_pkg.sv | 50 +++++
 rtl/local_ingress_buffer_fifo.sv | 85 ++++++++
 rtl/local_ingress_buffer.sv | 185 ++++++++++++++++++
 tb/tb_local_ingress_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_ingress_buffer_pkg.sv
// Shared types for the local ingress buffer: output port encoding, XY
// header field geometry, output FSM states and the XY route decoder.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package local_ingress_buffer_pkg;

  // Width of one coordinate field in the head flit.
  localparam int COORD_W = 7;
  // Both coordinate fields together, MSB-aligned in the flit data.
  localparam int HDR_W   = 2 * COORD_W;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    WEST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } out_state_e;

  // Dimension-ordered (X first, then Y) routing decision, unsigned compares.
  function automatic port_e route_calc(
    input logic [COORD_W-1:0] i_x,
    input logic [COORD_W-1:0] i_y,
    input logic [COORD_W-1:0] i_x_cur,
    input logic [COORD_W-1:0] i_y_cur
  );
    port_e w_dir;
    if (i_x > i_x_cur) begin
      w_dir = EAST;
    end else if (i_x < i_x_cur) begin
      w_dir = WEST;
    end else if (i_y > i_y_cur) begin
      w_dir = NORTH;
    end else if (i_y < i_y_cur) begin
      w_dir = SOUTH;
    end else begin
      w_dir = LOCAL;
    end
    return w_dir;
  endfunction

endpackage

// File: rtl/local_ingress_buffer_fifo.sv
// First-word-fall-through circular FIFO. The head entry is always visible
// on o_rd_data (zero while empty), and the header field of the entry just
// behind the head is exposed on o_peek_next so the owner can decode the
// next packet's route in the same cycle the current packet's tail leaves.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sync_flit_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = `DATA_WIDTH + 1,
  parameter int PEEK_W = 14
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [PEEK_W-1:0]        o_peek_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;
  logic [AW-1:0]    w_rd_ptr_inc;

  // Pointer advance with an explicit wrap from the last index back to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] i_ptr);
    logic [AW-1:0] w_nxt;
    if (i_ptr == AW'(DEPTH - 1)) begin
      w_nxt = {AW{1'b0}};
    end else begin
      w_nxt = i_ptr + AW'(1'b1);
    end
    return w_nxt;
  endfunction

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == {CW{1'b0}});
  assign w_wr         = i_wr_en & ~o_full;
  assign w_rd         = i_rd_en & ~o_empty;
  assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);
  assign o_count      = r_count;
  assign o_rd_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign o_peek_next  = r_mem[w_rd_ptr_inc][WIDTH-2 -: PEEK_W];

  // Storage array; contents need no reset since the empty flag masks them.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/local_ingress_buffer.sv
// Local (IP-side) ingress buffer of a mesh router. Flits are queued in a
// FWFT FIFO and released to the crossbar store-and-forward: a packet is
// presented only once its last flit is stored, unless the buffer fills up
// with a partial packet, in which case it is cut through to avoid deadlock.
// The FSM decides on the post-edge counters so that Valid_out can rise in
// the cycle straight after the tail flit is accepted.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module local_ingress_buffer
  import local_ingress_buffer_pkg::*;
#(
  parameter int X_CUR = 2,
  parameter int Y_CUR = 2,
  parameter int DEPTH = 8   // power of two, at least 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    Valid_IP,
  input  logic [`DATA_WIDTH-1:0]  Data_IP,
  input  logic                    Last_IP,
  output logic                    Ready_IP,
  output logic                    Valid_out,
  output logic [`DATA_WIDTH-1:0]  Data_out,
  output logic                    Last_out,
  input  logic                    Ready_out,
  output logic [2:0]              route_dir,
  output logic [$clog2(DEPTH):0]  flit_cnt,
  output logic [$clog2(DEPTH):0]  pkt_cnt,
  output logic                    cut_through
);

  localparam int DW = `DATA_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_CUR);

  logic [DW:0]       w_fifo_rd_data;
  logic [HDR_W-1:0]  w_fifo_peek;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;

  out_state_e        r_state;
  out_state_e        w_state_next;
  port_e             r_route;
  port_e             w_route_next;
  logic [CW-1:0]     r_pkt_cnt;
  logic [CW-1:0]     w_pkt_next;
  logic [CW-1:0]     w_flit_next;
  logic              r_ready;
  logic              r_cut;
  logic              w_cut_next;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_full_next;
  logic              w_eligible;
  logic              w_load_route;
  logic [HDR_W-1:0]  w_head_xy;

  sync_flit_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (DW + 1),
    .PEEK_W (HDR_W)
  ) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .i_wr_en     (w_wr_acc),
    .i_wr_data   ({Last_IP, Data_IP}),
    .i_rd_en     (w_rd_acc),
    .o_rd_data   (w_fifo_rd_data),
    .o_peek_next (w_fifo_peek),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign Data_out    = w_fifo_rd_data[DW-1:0];
  assign Last_out    = w_fifo_rd_data[DW];
  assign Valid_out   = (r_state != ST_IDLE) && !w_fifo_empty;
  assign Ready_IP    = r_ready;
  assign route_dir   = r_route;
  assign flit_cnt    = w_fifo_count;
  assign pkt_cnt     = r_pkt_cnt;
  assign cut_through = r_cut;

  assign w_wr_acc    = Valid_IP & r_ready & ~w_fifo_full;
  assign w_rd_acc    = Valid_out & Ready_out;
  assign w_full_next = (w_flit_next == CW'(DEPTH));
  assign w_eligible  = (w_pkt_next != {CW{1'b0}}) || w_full_next;

  // Post-edge flit and packet occupancy.
  always_comb begin
    w_flit_next = w_fifo_count;
    w_pkt_next  = r_pkt_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_flit_next = w_fifo_count + CW'(1'b1);
      2'b01:   w_flit_next = w_fifo_count - CW'(1'b1);
      default: w_flit_next = w_fifo_count;
    endcase
    case ({w_wr_acc & Last_IP, w_rd_acc & Last_out})
      2'b10:   w_pkt_next = r_pkt_cnt + CW'(1'b1);
      2'b01:   w_pkt_next = r_pkt_cnt - CW'(1'b1);
      default: w_pkt_next = r_pkt_cnt;
    endcase
  end

  // Header coordinates of whatever flit will be at the FIFO head after the edge.
  always_comb begin
    w_head_xy = Data_IP[DW-1 -: HDR_W];
    if (w_rd_acc) begin
      if (w_fifo_count > CW'(1'b1)) begin
        w_head_xy = w_fifo_peek;
      end else begin
        w_head_xy = Data_IP[DW-1 -: HDR_W];
      end
    end else begin
      if (!w_fifo_empty) begin
        w_head_xy = w_fifo_rd_data[DW-1 -: HDR_W];
      end else begin
        w_head_xy = Data_IP[DW-1 -: HDR_W];
      end
    end
  end

  // Output FSM next state, route capture and cut-through flag.
  always_comb begin
    w_state_next = r_state;
    w_load_route = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_state_next = ST_HEAD;
          w_load_route = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HEAD, ST_BODY: begin
        if (w_rd_acc && Last_out) begin
          if (w_eligible) begin
            w_state_next = ST_HEAD;
            w_load_route = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (w_rd_acc) begin
          w_state_next = ST_BODY;
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_load_route) begin
      w_route_next = route_calc(w_head_xy[HDR_W-1 -: COORD_W],
                                w_head_xy[COORD_W-1:0], X_C, Y_C);
    end else begin
      w_route_next = r_route;
    end
    // Entering HEAD with no complete packet stored means the full fallback.
    w_cut_next = r_cut | (w_load_route & (w_pkt_next == {CW{1'b0}}));
  end

  // Control state registers; Ready_IP is the registered inverse of post-edge full.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_route   <= LOCAL;
      r_pkt_cnt <= {CW{1'b0}};
      r_ready   <= 1'b0;
      r_cut     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_route   <= w_route_next;
      r_pkt_cnt <= w_pkt_next;
      r_ready   <= ~w_full_next;
      r_cut     <= w_cut_next;
    end
  end

endmodule

// File: tb/tb_local_ingress_buffer.sv
// Directed bench for local_ingress_buffer with a flit scoreboard: every
// accepted input flit pushes its expected {last, data, route}; every flit
// taken by the crossbar side pops and compares.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_local_ingress_buffer;

  localparam int DW = `DATA_WIDTH;
  localparam int XC = 2;
  localparam int YC = 2;
  localparam logic [2:0] R_LOCAL = 3'd0;
  localparam logic [2:0] R_EAST  = 3'd1;
  localparam logic [2:0] R_WEST  = 3'd2;
  localparam logic [2:0] R_NORTH = 3'd3;
  localparam logic [2:0] R_SOUTH = 3'd4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          Valid_IP;
  logic [DW-1:0] Data_IP;
  logic          Last_IP;
  logic          Ready_IP;
  logic          Valid_out;
  logic [DW-1:0] Data_out;
  logic          Last_out;
  logic          Ready_out;
  logic [2:0]    route_dir;
  logic [3:0]    flit_cnt;
  logic [3:0]    pkt_cnt;
  logic          cut_through;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
    logic [2:0]    route;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  local_ingress_buffer #(.X_CUR(XC), .Y_CUR(YC), .DEPTH(8)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .Valid_IP    (Valid_IP),
    .Data_IP     (Data_IP),
    .Last_IP     (Last_IP),
    .Ready_IP    (Ready_IP),
    .Valid_out   (Valid_out),
    .Data_out    (Data_out),
    .Last_out    (Last_out),
    .Ready_out   (Ready_out),
    .route_dir   (route_dir),
    .flit_cnt    (flit_cnt),
    .pkt_cnt     (pkt_cnt),
    .cut_through (cut_through)
  );

  function automatic logic [2:0] exp_route(input int x, input int y);
    if (x > XC) return R_EAST;
    else if (x < XC) return R_WEST;
    else if (y > YC) return R_NORTH;
    else if (y < YC) return R_SOUTH;
    else return R_LOCAL;
  endfunction

  function automatic logic [DW-1:0] hdr(input int x, input int y);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[DW-1 -: 7] = x[6:0];
    d[DW-8 -: 7] = y[6:0];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one flit until accepted (bounded), recording it in the scoreboard.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic [2:0] rt);
    int   t;
    exp_t e;
    Valid_IP = 1'b1;
    Data_IP  = d;
    Last_IP  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (Ready_IP || t > 50) break;
      t++;
    end
    chk("send_accept", {31'd0, Ready_IP}, 32'd1);
    if (Ready_IP) begin
      e.last  = last;
      e.data  = d;
      e.route = rt;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    Valid_IP = 1'b0;
    Last_IP  = 1'b0;
  endtask

  task automatic send_pkt(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) begin
      send((i == 0) ? hdr(x, y) : DW'($urandom), (i == n - 1), exp_route(x, y));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, sb_q.size(), 32'd0);
  endtask

  // Output monitor: a flit transfers at the next rising edge when valid and ready are high now.
  always @(negedge clk) begin
    if (nreset && Valid_out && Ready_out) begin
      n_checks++;
      assert (sb_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_flit observed=0x%0h expected=none", Data_out);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("out_data", Data_out, mon_e.data);
        chk("out_last", {31'd0, Last_out}, {31'd0, mon_e.last});
        chk("out_route", {29'd0, route_dir}, {29'd0, mon_e.route});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            hx [4];
    int            hy [4];
    logic [2:0]    hr [4];
    hx = '{2, 1, 2, 2};
    hy = '{2, 2, 3, 0};
    hr = '{R_LOCAL, R_WEST, R_NORTH, R_SOUTH};

    nreset    = 1'b0;
    Valid_IP  = 1'b0;
    Data_IP   = '0;
    Last_IP   = 1'b0;
    Ready_out = 1'b0;
    tick(3);

    // Reset state.
    chk("rst_ready_ip", {31'd0, Ready_IP}, 32'd0);
    chk("rst_valid_out", {31'd0, Valid_out}, 32'd0);
    chk("rst_cut", {31'd0, cut_through}, 32'd0);
    chk("rst_flit_cnt", {28'd0, flit_cnt}, 32'd0);
    chk("rst_pkt_cnt", {28'd0, pkt_cnt}, 32'd0);
    chk("rst_route", {29'd0, route_dir}, {29'd0, R_LOCAL});
    chk("rst_data_out", Data_out, 32'd0);
    chk("rst_last_out", {31'd0, Last_out}, 32'd0);
    nreset = 1'b1;
    tick(1);
    chk("post_rst_ready", {31'd0, Ready_IP}, 32'd1);
    chk("post_rst_valid", {31'd0, Valid_out}, 32'd0);

    // 4-flit packet to (3,2): store-and-forward, EAST, back-to-back drain.
    Ready_out = 1'b1;
    send(hdr(3, 2), 1'b0, R_EAST);
    send(DW'($urandom), 1'b0, R_EAST);
    send(DW'($urandom), 1'b0, R_EAST);
    chk("saf_hold_valid", {31'd0, Valid_out}, 32'd0);
    chk("saf_pkt0", {28'd0, pkt_cnt}, 32'd0);
    send(DW'($urandom), 1'b1, R_EAST);
    chk("saf_rise", {31'd0, Valid_out}, 32'd1);
    chk("saf_pkt1", {28'd0, pkt_cnt}, 32'd1);
    chk("saf_route", {29'd0, route_dir}, {29'd0, R_EAST});
    tick(4);
    chk("b2b_drained", sb_q.size(), 32'd0);
    chk("b2b_pkt0", {28'd0, pkt_cnt}, 32'd0);
    chk("b2b_idle", {31'd0, Valid_out}, 32'd0);

    // Single-flit packets covering the remaining directions.
    for (int i = 0; i < 4; i++) begin
      send(hdr(hx[i], hy[i]), 1'b1, hr[i]);
      chk("single_route", {29'd0, route_dir}, {29'd0, hr[i]});
      chk("single_valid", {31'd0, Valid_out}, 32'd1);
      wait_drain("single_drain", 10);
      chk("single_idle", {31'd0, Valid_out}, 32'd0);
    end

    // Fill with two 4-flit packets while the crossbar stalls.
    Ready_out = 1'b0;
    send_pkt(0, 5, 4);
    send_pkt(2, 7, 4);
    chk("full_ready", {31'd0, Ready_IP}, 32'd0);
    chk("full_flit", {28'd0, flit_cnt}, 32'd8);
    chk("full_pkt", {28'd0, pkt_cnt}, 32'd2);
    chk("full_no_cut", {31'd0, cut_through}, 32'd0);
    Valid_IP = 1'b1;
    Data_IP  = DW'($urandom);
    Last_IP  = 1'b1;
    tick(2);
    Valid_IP = 1'b0;
    Last_IP  = 1'b0;
    chk("ninth_refused", {28'd0, flit_cnt}, 32'd8);
    chk("ninth_pkt", {28'd0, pkt_cnt}, 32'd2);
    Ready_out = 1'b1;
    wait_drain("full_drain", 40);
    tick(1);
    chk("full_end_flit", {28'd0, flit_cnt}, 32'd0);
    chk("full_end_pkt", {28'd0, pkt_cnt}, 32'd0);

    // 10-flit packet: cut-through fallback once the buffer is full.
    Ready_out = 1'b0;
    send(hdr(4, 2), 1'b0, R_EAST);
    for (int i = 1; i < 8; i++) send(DW'($urandom), 1'b0, R_EAST);
    chk("ct_ready", {31'd0, Ready_IP}, 32'd0);
    chk("ct_pkt0", {28'd0, pkt_cnt}, 32'd0);
    chk("ct_flit8", {28'd0, flit_cnt}, 32'd8);
    chk("ct_flag", {31'd0, cut_through}, 32'd1);
    chk("ct_valid", {31'd0, Valid_out}, 32'd1);
    chk("ct_route", {29'd0, route_dir}, {29'd0, R_EAST});
    Ready_out = 1'b1;
    send(DW'($urandom), 1'b0, R_EAST);
    send(DW'($urandom), 1'b1, R_EAST);
    wait_drain("ct_drain", 40);
    tick(1);
    chk("ct_end_pkt", {28'd0, pkt_cnt}, 32'd0);
    chk("ct_end_flit", {28'd0, flit_cnt}, 32'd0);
    chk("ct_sticky", {31'd0, cut_through}, 32'd1);

    // Simultaneous read and write at flit_cnt=3.
    Ready_out = 1'b0;
    send(hdr(1, 1), 1'b0, R_WEST);
    send(DW'($urandom), 1'b1, R_WEST);
    send(hdr(3, 3), 1'b0, R_EAST);
    chk("stream_pre_flit", {28'd0, flit_cnt}, 32'd3);
    chk("stream_pre_pkt", {28'd0, pkt_cnt}, 32'd1);
    Ready_out = 1'b1;
    send(DW'($urandom), 1'b0, R_EAST);
    chk("stream_flit1", {28'd0, flit_cnt}, 32'd3);
    send(DW'($urandom), 1'b1, R_EAST);
    chk("stream_flit2", {28'd0, flit_cnt}, 32'd3);
    chk("stream_route_next", {29'd0, route_dir}, {29'd0, R_EAST});
    wait_drain("stream_drain", 20);
    tick(1);
    chk("stream_end_flit", {28'd0, flit_cnt}, 32'd0);

    // Reset with 2 of 4 flits stored, then a clean packet.
    Ready_out = 1'b0;
    send(hdr(2, 1), 1'b0, R_SOUTH);
    send(DW'($urandom), 1'b0, R_SOUTH);
    chk("midrst_pre_flit", {28'd0, flit_cnt}, 32'd2);
    nreset = 1'b0;
    sb_q.delete();
    tick(1);
    chk("midrst_in_flit", {28'd0, flit_cnt}, 32'd0);
    chk("midrst_in_ready", {31'd0, Ready_IP}, 32'd0);
    nreset = 1'b1;
    tick(1);
    chk("midrst_flit", {28'd0, flit_cnt}, 32'd0);
    chk("midrst_valid", {31'd0, Valid_out}, 32'd0);
    chk("midrst_ready", {31'd0, Ready_IP}, 32'd1);
    chk("midrst_pkt", {28'd0, pkt_cnt}, 32'd0);
    chk("midrst_cut", {31'd0, cut_through}, 32'd0);
    Ready_out = 1'b1;
    send_pkt(2, 1, 4);
    wait_drain("midrst_drain", 20);
    tick(1);
    chk("midrst_end_pkt", {28'd0, pkt_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
